// File: rtl/mux2x1_8bits.sv
`default_nettype none
// ============================================================================
// Module   : mux2x1_8bits
// Brief    : Two-lane to one-lane serializer for the 8-bit data path. A pair
//            {lane 00, lane 11} is taken once every two clocks and emitted on
//            a single lane, lane 00 first. Pair alignment is owned here and
//            exported upstream through pair_take.
// Revision : 1.0 - initial release
// ============================================================================
module mux2x1_8bits #(
    parameter int IDLE_PAIRS = 4
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic [7:0] data_00,
    input  logic       valid_00,
    input  logic [7:0] data_11,
    input  logic       valid_11,
    output logic       pair_take,
    output logic [7:0] data_000_cond,
    output logic       valid_000_cond,
    output logic       synced
);

    localparam int CNT_W = $clog2(IDLE_PAIRS + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_PAIRS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic             p, p_nx;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
    logic [8:0]       hold_11, hold_11_nx;
    logic [8:0]       out_word, out_word_nx;

    // Lanes with valid=0 are forced to data 0 so idle words are always 00/0.
    logic [8:0] lane_00;
    logic [8:0] lane_11;
    logic       any_valid;

    assign lane_00   = {(valid_00 ? data_00 : 8'h00), valid_00};
    assign lane_11   = {(valid_11 ? data_11 : 8'h00), valid_11};
    assign any_valid = valid_00 | valid_11;

    // In IDLE every edge may capture; in RUN only the even phase captures.
    assign pair_take = (state == ST_IDLE) | (p == 1'b0);

    assign data_000_cond  = out_word[8:1];
    assign valid_000_cond = out_word[0];

    // State register with asynchronous clear; reset also drops any held lane 11.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_IDLE;
            p        <= 1'b0;
            idle_cnt <= '0;
            hold_11  <= '0;
            out_word <= '0;
            synced   <= 1'b0;
        end else begin
            state    <= state_nx;
            p        <= p_nx;
            idle_cnt <= idle_cnt_nx;
            hold_11  <= hold_11_nx;
            out_word <= out_word_nx;
            synced   <= (state_nx == ST_RUN);
        end
    end

    // Next-state, capture/serialize and idle-pair detection.
    always_comb begin
        state_nx    = state;
        p_nx        = p;
        idle_cnt_nx = idle_cnt;
        hold_11_nx  = hold_11;
        out_word_nx = out_word;

        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    // First active pair fixes the phase.
                    out_word_nx = lane_00;
                    hold_11_nx  = lane_11;
                    p_nx        = 1'b1;
                    idle_cnt_nx = '0;
                    state_nx    = ST_RUN;
                end else begin
                    out_word_nx = '0;
                    p_nx        = 1'b0;
                end
            end
            ST_RUN: begin
                if (!p) begin
                    out_word_nx = lane_00;
                    hold_11_nx  = lane_11;
                    p_nx        = 1'b1;
                    idle_cnt_nx = any_valid ? '0 : idle_cnt + CNT_W'(1);
                end else begin
                    // Lane 11 slot; the last idle pair still finishes here.
                    out_word_nx = hold_11;
                    p_nx        = 1'b0;
                    if (idle_cnt == IDLE_MAX) begin
                        state_nx    = ST_IDLE;
                        idle_cnt_nx = '0;
                    end
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                p_nx        = 1'b0;
                idle_cnt_nx = '0;
                out_word_nx = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mux2x1_8bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2x1_8bits
// Brief    : Scoreboard bench for mux2x1_8bits. The driver issues directed
//            pairs and queues the hand-computed word expected after each
//            edge; a monitor pops and compares once per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2x1_8bits;

    logic       clk_4f = 1'b0;
    logic       reset_L;
    logic [7:0] data_00;
    logic       valid_00;
    logic [7:0] data_11;
    logic       valid_11;
    logic       pair_take;
    logic [7:0] data_000_cond;
    logic       valid_000_cond;
    logic       synced;

    int tests = 0;
    int fails = 0;

    // {data, valid, synced} expected after each rising edge
    logic [9:0] exp_q[$];

    mux2x1_8bits #(.IDLE_PAIRS(4)) dut (
        .clk_4f         (clk_4f),
        .reset_L        (reset_L),
        .data_00        (data_00),
        .valid_00       (valid_00),
        .data_11        (data_11),
        .valid_11       (valid_11),
        .pair_take      (pair_take),
        .data_000_cond  (data_000_cond),
        .valid_000_cond (valid_000_cond),
        .synced         (synced)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; expected word is what the outputs show after the edge.
    task automatic step(input logic [7:0] d0, input logic v0,
                        input logic [7:0] d1, input logic v1,
                        input logic exp_take,
                        input logic [7:0] ed, input logic ev, input logic es);
        data_00  = d0;
        valid_00 = v0;
        data_11  = d1;
        valid_11 = v1;
        #1;
        check("pair_take", {31'd0, pair_take}, {31'd0, exp_take});
        exp_q.push_back({ed, ev, es});
        @(posedge clk_4f);
        @(negedge clk_4f);
    endtask

    task automatic idle_step(input logic es);
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, es);
    endtask

    // A pair held for two clocks: capture edge, then lane-11 edge.
    task automatic pair(input logic [7:0] d0, input logic v0,
                        input logic [7:0] d1, input logic v1,
                        input logic [7:0] e0d, input logic e0v, input logic e0s,
                        input logic [7:0] e1d, input logic e1v, input logic e1s);
        step(d0, v0, d1, v1, 1'b1, e0d, e0v, e0s);
        step(d0, v0, d1, v1, 1'b0, e1d, e1v, e1s);
    endtask

    // Monitor: compares the outputs once per clock against the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk_4f);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_out",  {24'd0, data_000_cond},  {24'd0, e[9:2]});
                check("valid_out", {31'd0, valid_000_cond}, {31'd0, e[1]});
                check("synced",    {31'd0, synced},         {31'd0, e[0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L  = 1'b0;
        data_00  = 8'h00;
        valid_00 = 1'b0;
        data_11  = 8'h00;
        valid_11 = 1'b0;
        repeat (2) @(negedge clk_4f);
        check("rst_data",  {24'd0, data_000_cond},  32'h0);
        check("rst_valid", {31'd0, valid_000_cond}, 32'h0);
        check("rst_synced", {31'd0, synced},        32'h0);
        check("rst_take",  {31'd0, pair_take},      32'h1);
        reset_L = 1'b1;

        // Idle after reset, then first pair
        repeat (5) idle_step(1'b0);
        pair(8'hA5, 1, 8'h3C, 1, 8'hA5, 1, 1, 8'h3C, 1, 1);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            pair(8'h10 + 8'(i), 1, 8'h80 + 8'(i), 1,
                 8'h10 + 8'(i), 1, 1, 8'h80 + 8'(i), 1, 1);
        end

        // Three idle pairs, then a half-valid pair must clear the count
        for (int i = 0; i < 3; i++) begin
            pair(8'hC3, 0, 8'h7E, 0, 8'h00, 0, 1, 8'h00, 0, 1);
        end
        pair(8'hFF, 0, 8'h55, 1, 8'h00, 0, 1, 8'h55, 1, 1);

        // Four idle pairs: synced falls with the eighth invalid word
        for (int i = 0; i < 3; i++) begin
            pair(8'hC3, 0, 8'h7E, 0, 8'h00, 0, 1, 8'h00, 0, 1);
        end
        pair(8'hC3, 0, 8'h7E, 0, 8'h00, 0, 1, 8'h00, 0, 0);

        // Back in IDLE; re-align at odd phase
        idle_step(1'b0);
        pair(8'h66, 1, 8'h99, 1, 8'h66, 1, 1, 8'h99, 1, 1);
        pair(8'h22, 1, 8'h44, 0, 8'h22, 1, 1, 8'h00, 0, 1);

        // Reset between lane-00 and lane-11 output cycles
        step(8'h5A, 1, 8'hA5, 1, 1'b1, 8'h5A, 1, 1);
        reset_L = 1'b0;
        #1;
        check("async_data",   {24'd0, data_000_cond},  32'h0);
        check("async_valid",  {31'd0, valid_000_cond}, 32'h0);
        check("async_synced", {31'd0, synced},         32'h0);
        check("async_take",   {31'd0, pair_take},      32'h1);
        @(posedge clk_4f);
        #1;
        check("rst_hold_data", {24'd0, data_000_cond}, 32'h0);
        @(negedge clk_4f);
        reset_L = 1'b1;
        idle_step(1'b0);
        idle_step(1'b0);

        repeat (2) @(posedge clk_4f);
        #2;
        check("scoreboard_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2x1_8bits.md
# mux2x1_8bits

Two-lane to one-lane serializer for the 8-bit data path. It accepts a pair of lanes (lane 00, lane 11), each carrying `{data, valid}`, once every two clock cycles. It emits them on a single lane at full clock rate, lane 00 first and lane 11 second. It sits on the transmit side, feeding the single serial lane that the 1-to-2 demux splits back into two lanes. Pair alignment is owned here and exported to upstream through `pair_take`.

## Interface
Parameters:
- `IDLE_PAIRS`, default 4: number of consecutive all-invalid pairs after which the block drops back to IDLE and re-aligns.

Ports:
- `clk_4f`, input, 1: the only clock; the lane rate on the output side. All logic is on its rising edge.
- `reset_L`, input, 1: asynchronous, active-low reset.
- `data_00`, input, 8: lane 00 data.
- `valid_00`, input, 1: lane 00 valid.
- `data_11`, input, 8: lane 11 data.
- `valid_11`, input, 1: lane 11 valid.
- `pair_take`, output, 1: combinational. When high, the current pair is captured on the next rising edge. Upstream advances to its next pair after that edge.
- `data_000_cond`, output, 8: serialized data, registered.
- `valid_000_cond`, output, 1: serialized valid, registered.
- `synced`, output, 1: high while in RUN, registered.

## Operation
- States: IDLE and RUN. Internal registers:
  - phase bit `p`
  - lane-11 holding register `hold_11` (9 bits, `{data,valid}`)
  - idle-pair counter `idle_cnt`, width `$clog2(IDLE_PAIRS+1)`
- `pair_take` = (state==IDLE) | (state==RUN & p==0).
- IDLE:
  - Every cycle is a capture opportunity.
  - If `valid_00 | valid_11` is sampled high: capture the pair, go to RUN, set p<=1, set idle_cnt<=0.
  - Otherwise the outputs are driven to 0.
- Capture edge (pair_take=1, and in RUN or leaving IDLE):
  - Output register <= lane 00.
  - `hold_11` <= `{data_11, valid_11}`.
  - Then p<=1.
- RUN with p==1: output register <= `hold_11`; p<=0.
- Invalid-lane masking: any word emitted with valid=0 carries data 8'h00, whatever the input data.
- Idle detection, evaluated on RUN capture edges:
  - If `valid_00==0` and `valid_11==0`: idle_cnt increments.
  - Otherwise idle_cnt clears.
  - When the increment reaches IDLE_PAIRS, the state goes to IDLE on the following p==1 edge, after lane 11 (invalid) has been emitted. p<=0 and idle_cnt<=0.
- `synced` <= (next state == RUN).
- Upstream contract: the pair is held stable from the edge after the previous `pair_take` until the capture edge. The block never back-pressures.

## Timing
- Reset (`reset_L`=0, asynchronous): state=IDLE, p=0, idle_cnt=0, hold_11=0, `data_000_cond`=8'h00, `valid_000_cond`=0, `synced`=0.
  - `pair_take`=1 during reset.
  - Reset mid-pair discards `hold_11`. Lane 11 of an interrupted pair is never emitted.
- Latency:
  - Lane 00 appears on the outputs 1 cycle after its capture edge.
  - Lane 11 appears 1 cycle after lane 00.
- Throughput in RUN: one pair per 2 cycles. The output carries a new word every cycle, with no bubbles.
- Alignment: the first capture in IDLE fixes the phase. Afterwards capture edges are exactly every 2 cycles until return to IDLE.
- One valid lane in a pair: the pair counts as active and idle_cnt clears.
- IDLE_PAIRS reached with the final invalid pair:
  - That pair is still serialized (two invalid words).
  - IDLE is entered after the lane-11 slot.
  - `synced` falls in the same cycle.
- IDLE with all-invalid input: outputs stay at 0 and `pair_take` stays 1.

## Test plan
- Reset then stimulus:
  - Stimulus: release `reset_L`, hold inputs at 0 for 5 cycles, then present pair (8'hA5,1 / 8'h3C,1).
  - Required: outputs 0 while idle; `pair_take`=1 throughout idle; capture on first valid edge; output 8'hA5/1 then 8'h3C/1 on the next two cycles; `synced`=1 from the capture edge.
- Stream of 8 back-to-back pairs:
  - Stimulus: pairs (8'h10+i, 8'h80+i), all valid, upstream advancing on `pair_take`.
  - Required: output sequence 10,80,11,81,...,17,87 with valid=1 on every cycle; `pair_take` toggles 1,0 each cycle.
- Masking:
  - Stimulus: pair (8'hFF,0 / 8'h55,1).
  - Required: output 8'h00/0 then 8'h55/1; idle_cnt stays 0.
- Idle exit with IDLE_PAIRS=4:
  - Stimulus: 4 all-invalid pairs in RUN.
  - Required: 8 output words of 00/0; `synced` falls after the 8th; the next valid pair re-aligns on its first edge, even at odd phase.
- Asynchronous reset mid-pair:
  - Stimulus: assert `reset_L`=0 between the lane-00 and lane-11 output cycles.
  - Required: outputs 0 immediately, without waiting for a clock edge; lane 11 is never emitted; `synced`=0.
